// File: rtl/l2_tag_sram_ctrl_if.sv
// Bundle of lookup, fill, flush and SRAM-macro signals for the L2 tag controller.
// slave = controller view, master = requester/macro view.
interface l2_tag_sram_ctrl_if #(
    parameter int DATA_WIDTH = 19,
    parameter int ADDR_WIDTH = 7
);
    logic                  rd0_valid;
    logic [ADDR_WIDTH-1:0] rd0_addr;
    logic                  rd0_ready;
    logic                  rd1_valid;
    logic [ADDR_WIDTH-1:0] rd1_addr;
    logic                  rd1_ready;
    logic                  rsp_valid;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  flush_req;
    logic                  busy;
    logic                  sram_csb0;
    logic [ADDR_WIDTH-1:0] sram_addr0;
    logic [DATA_WIDTH-1:0] sram_din0;
    logic                  sram_csb1;
    logic [ADDR_WIDTH-1:0] sram_addr1;
    logic [DATA_WIDTH-1:0] sram_dout1;

    modport slave (
        input  rd0_valid, rd0_addr, rd1_valid, rd1_addr,
        input  wr_valid, wr_addr, wr_data, flush_req, sram_dout1,
        output rd0_ready, rd1_ready, rsp_valid, rsp_id, rsp_data,
        output wr_ready, busy, sram_csb0, sram_addr0, sram_din0,
        output sram_csb1, sram_addr1
    );

    modport master (
        output rd0_valid, rd0_addr, rd1_valid, rd1_addr,
        output wr_valid, wr_addr, wr_data, flush_req, sram_dout1,
        input  rd0_ready, rd1_ready, rsp_valid, rsp_id, rsp_data,
        input  wr_ready, busy, sram_csb0, sram_addr0, sram_din0,
        input  sram_csb1, sram_addr1
    );
endinterface

// File: rtl/l2_tag_sram_ctrl.sv
// L2 tag SRAM controller: post-reset/flush clear sweep, round-robin lookup
// arbitration onto the read port, fill pass-through and same-address bypass.
module l2_tag_sram_ctrl #(
    parameter int DATA_WIDTH = 19,
    parameter int ADDR_WIDTH = 7,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input logic               clk,
    input logic               rst,
    l2_tag_sram_ctrl_if.slave bus
);
    typedef enum logic {CLEAR, RUN} state_e;

    localparam logic [ADDR_WIDTH:0] CLEAR_LAST = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   clear_ptr_q, clear_ptr_d;
    logic                  rr_last_q, rr_last_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic                  grant;
    logic                  gid;
    logic [ADDR_WIDTH-1:0] gaddr;
    logic                  collide;

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        rr_last_d   = rr_last_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;

        bus.rd0_ready  = 1'b0;
        bus.rd1_ready  = 1'b0;
        bus.wr_ready   = 1'b0;
        bus.busy       = rst;
        bus.sram_csb0  = 1'b1;
        bus.sram_addr0 = '0;
        bus.sram_din0  = '0;
        bus.sram_csb1  = 1'b1;
        bus.sram_addr1 = '0;

        grant   = 1'b0;
        gid     = 1'b0;
        gaddr   = '0;
        collide = 1'b0;

        // Macro ports stay deselected while reset is held.
        if (!rst) begin
            unique case (state_q)
                CLEAR: begin
                    bus.busy       = 1'b1;
                    bus.sram_csb0  = 1'b0;
                    bus.sram_addr0 = clear_ptr_q[ADDR_WIDTH-1:0];
                    if (clear_ptr_q == CLEAR_LAST) begin
                        clear_ptr_d = '0;
                        state_d     = RUN;
                    end else begin
                        clear_ptr_d = clear_ptr_q + 1'b1;
                    end
                end
                RUN: begin
                    bus.wr_ready = 1'b1;
                    if (bus.wr_valid) begin
                        bus.sram_csb0  = 1'b0;
                        bus.sram_addr0 = bus.wr_addr;
                        bus.sram_din0  = bus.wr_data;
                    end

                    if (bus.rd0_valid && bus.rd1_valid) begin
                        grant     = 1'b1;
                        gid       = ~rr_last_q;
                        rr_last_d = ~rr_last_q;
                    end else if (bus.rd0_valid) begin
                        grant = 1'b1;
                        gid   = 1'b0;
                    end else if (bus.rd1_valid) begin
                        grant = 1'b1;
                        gid   = 1'b1;
                    end
                    gaddr = gid ? bus.rd1_addr : bus.rd0_addr;

                    if (grant) begin
                        collide        = bus.wr_valid && (bus.wr_addr == gaddr);
                        bus.rd0_ready  = ~gid;
                        bus.rd1_ready  = gid;
                        bus.sram_csb1  = collide;
                        bus.sram_addr1 = gaddr;
                        rsp_valid_d    = 1'b1;
                        rsp_id_d       = gid;
                        // A colliding read returns the data being written instead of the macro.
                        rsp_data_d     = collide ? bus.wr_data : bus.sram_dout1;
                    end

                    if (bus.flush_req) begin
                        state_d     = CLEAR;
                        clear_ptr_d = '0;
                    end
                end
                default: state_d = CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clear_ptr_q <= '0;
            rr_last_q   <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            rr_last_q   <= rr_last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_l2_tag_sram_ctrl.sv
// Randomized bench for l2_tag_sram_ctrl: behavioural SRAM macro plus a
// transaction-level reference model of sweep, arbitration and responses.
module tb_l2_tag_sram_ctrl;
    localparam int DW    = 19;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_tag_sram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    l2_tag_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] garbage(input int i);
        return DW'((i * 7919) ^ 32'h2A5A5);
    endfunction

    // Behavioural macro: write at the clock edge, read data available within the cycle.
    logic [DW-1:0] macro_mem [DEPTH];
    logic          init_mem = 1'b1;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < DEPTH; i++) macro_mem[i] <= garbage(i);
        end else if (!bus.sram_csb0) begin
            macro_mem[bus.sram_addr0] <= bus.sram_din0;
        end
    end
    assign bus.sram_dout1 = bus.sram_csb1 ? 19'h2AAAA : macro_mem[bus.sram_addr1];

    int n_checks = 0;
    int n_bad    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit            m_clearing;
    int            m_sweep;
    int            m_last_winner;
    logic [DW-1:0] m_mem [DEPTH];
    bit            e_rv;
    int            e_rid;
    logic [DW-1:0] e_rdata;

    task automatic model_reset();
        m_clearing    = 1;
        m_sweep       = 0;
        m_last_winner = 1;
        e_rv          = 0;
        e_rid         = 0;
        e_rdata       = '0;
    endtask

    task automatic step(input bit r, input bit v0, input int a0, input bit v1, input int a1,
                        input bit wv, input int wa, input logic [DW-1:0] wd, input bit fl);
        int  g;
        int  ga;
        bit  coll;
        @(negedge clk);
        rst           = r;
        bus.rd0_valid = v0;
        bus.rd0_addr  = AW'(a0);
        bus.rd1_valid = v1;
        bus.rd1_addr  = AW'(a1);
        bus.wr_valid  = wv;
        bus.wr_addr   = AW'(wa);
        bus.wr_data   = wd;
        bus.flush_req = fl;
        #1;

        g = -1;
        if (!r && !m_clearing) begin
            if (v0 && v1) g = (m_last_winner == 0) ? 1 : 0;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        ga   = (g == 1) ? a1 : a0;
        coll = (g >= 0) && wv && (wa == ga);

        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
        chk("rsp_id",    32'(bus.rsp_id),    32'(e_rid));
        chk("rsp_data",  32'(bus.rsp_data),  32'(e_rdata));
        chk("busy",      32'(bus.busy),      32'(r || m_clearing));
        chk("wr_ready",  32'(bus.wr_ready),  32'(!r && !m_clearing));
        chk("rd0_ready", 32'(bus.rd0_ready), 32'(g == 0));
        chk("rd1_ready", 32'(bus.rd1_ready), 32'(g == 1));
        if (r) begin
            chk("csb0_rst", 32'(bus.sram_csb0), 32'd1);
        end else if (m_clearing) begin
            chk("csb0_clr",  32'(bus.sram_csb0),  32'd0);
            chk("addr0_clr", 32'(bus.sram_addr0), 32'(m_sweep));
            chk("din0_clr",  32'(bus.sram_din0),  32'd0);
        end else begin
            chk("csb0_run", 32'(bus.sram_csb0), 32'(!wv));
            if (wv) begin
                chk("addr0_wr", 32'(bus.sram_addr0), 32'(wa));
                chk("din0_wr",  32'(bus.sram_din0),  32'(wd));
            end
        end
        chk("csb1", 32'(bus.sram_csb1), 32'(!((g >= 0) && !coll)));
        if ((g >= 0) && !coll) chk("addr1", 32'(bus.sram_addr1), 32'(ga));
        if (!bus.sram_csb0 && !bus.sram_csb1)
            chk("same_addr_rw", 32'(bus.sram_addr0 == bus.sram_addr1), 32'd0);

        if (r) begin
            model_reset();
        end else if (m_clearing) begin
            m_mem[m_sweep] = '0;
            e_rv = 0;
            if (m_sweep == DEPTH - 1) begin
                m_clearing = 0;
                m_sweep    = 0;
            end else begin
                m_sweep++;
            end
        end else begin
            e_rv = (g >= 0);
            if (g >= 0) begin
                e_rid   = g;
                e_rdata = coll ? wd : m_mem[ga];
            end
            if (v0 && v1) m_last_winner = g;
            if (wv) m_mem[wa] = wd;
            if (fl) begin
                m_clearing = 1;
                m_sweep    = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    int busy_cnt;

    initial begin
        bus.rd0_valid = 0; bus.rd0_addr = '0;
        bus.rd1_valid = 0; bus.rd1_addr = '0;
        bus.wr_valid  = 0; bus.wr_addr  = '0; bus.wr_data = '0;
        bus.flush_req = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = garbage(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        init_mem = 1'b0;
        model_reset();

        // Reset state, then a full sweep of exactly DEPTH busy cycles
        step(1, 0, 0, 0, 0, 0, 0, '0, 0);
        busy_cnt = 0;
        for (int i = 0; i < 130; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, '0, 0);
            if (bus.busy) busy_cnt++;
        end
        chk("sweep_len", 32'(busy_cnt), 32'd128);

        // Write then read back
        step(0, 0, 0, 0, 0, 1, 5, 19'h40ABC, 0);
        step(0, 1, 5, 0, 0, 0, 0, '0, 0);
        idle(1);
        chk("rd_after_wr", 32'(bus.rsp_data), 32'h40ABC);

        // Contention alternates
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 2, 0, 0, '0, 0);
        idle(1);

        // Same-address read/write bypass
        step(0, 0, 0, 1, 9, 1, 9, 19'h7FFFF, 0);
        idle(1);
        chk("bypass_data", 32'(bus.rsp_data), 32'h7FFFF);

        // Flush with a granted lookup, then read after the new sweep
        step(0, 1, 5, 0, 0, 0, 0, '0, 1);
        busy_cnt = 0;
        for (int i = 0; i < 129; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, '0, 0);
            if (bus.busy) busy_cnt++;
        end
        chk("flush_sweep_len", 32'(busy_cnt), 32'd128);
        step(0, 1, 5, 0, 0, 0, 0, '0, 0);
        idle(1);
        chk("rd_after_flush", 32'(bus.rsp_data), 32'd0);

        // Reset mid-sweep restarts it
        step(0, 0, 0, 0, 0, 0, 0, '0, 1);
        idle(60);
        step(1, 0, 0, 0, 0, 0, 0, '0, 0);
        busy_cnt = 0;
        for (int i = 0; i < 130; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, '0, 0);
            if (bus.busy) busy_cnt++;
        end
        chk("rst_sweep_len", 32'(busy_cnt), 32'd128);

        // Randomized traffic, narrow address range to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            bit wide;
            wide = ($urandom_range(0, 7) == 0);
            step(($urandom_range(0, 599) == 0),
                 $urandom_range(0, 1), wide ? $urandom_range(0, 127) : $urandom_range(0, 7),
                 $urandom_range(0, 1), wide ? $urandom_range(0, 127) : $urandom_range(0, 7),
                 $urandom_range(0, 1), wide ? $urandom_range(0, 127) : $urandom_range(0, 7),
                 DW'($urandom), ($urandom_range(0, 249) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
